// File: rtl/wav_ddr_pkg.sv
// Shared types and widths for the byte-wide DDRAM port.
// Lanes are 8-bit slices of one 64-bit DDRAM word.
package wav_ddr_pkg;

    localparam int LANES   = 8;
    localparam int LANE_W  = 3;
    localparam int ADDR_W  = 28;
    localparam int TAG_W   = ADDR_W - LANE_W;
    localparam int WADDR_W = 29;
    localparam int LINE_W  = LANES * 8;

    typedef enum logic [1:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ
    } state_e;

    function automatic logic [LANES-1:0] lane_be(input logic [LANE_W-1:0] lane);
        lane_be = {{(LANES-1){1'b0}}, 1'b1} << lane;
    endfunction

endpackage

// File: rtl/wav_ddr_byte_port.sv
// Byte-wide request port onto a 64-bit DDRAM bus, with a single-line
// read cache that is kept coherent by write-through.
module wav_ddr_byte_port
    import wav_ddr_pkg::*;
#(
    parameter logic [3:0] BASE = 4'h3
) (
    input  logic                 I_CLK,
    input  logic                 I_RSTn,
    input  logic [ADDR_W-1:0]    I_ADDR,
    input  logic                 I_RD,
    input  logic                 I_WR,
    input  logic [7:0]           I_DIN,
    output logic [7:0]           O_DOUT,
    output logic                 O_READY,
    output logic [WADDR_W-1:0]   O_DDRAM_ADDR,
    output logic [7:0]           O_DDRAM_BURSTCNT,
    output logic                 O_DDRAM_RD,
    output logic                 O_DDRAM_WE,
    output logic [LINE_W-1:0]    O_DDRAM_DIN,
    output logic [LANES-1:0]     O_DDRAM_BE,
    input  logic                 I_DDRAM_BUSY,
    input  logic [LINE_W-1:0]    I_DDRAM_DOUT,
    input  logic                 I_DDRAM_DOUT_READY
);

    state_e              state_q;
    logic                ready_q;
    logic [TAG_W-1:0]    req_tag_q;
    logic [LANE_W-1:0]   req_lane_q;
    logic [TAG_W-1:0]    tag_q;
    logic                valid_q;
    logic [LINE_W-1:0]   line_q;
    logic [7:0]          dout_q;
    logic                rd_q;
    logic                we_q;
    logic [LINE_W-1:0]   ddr_din_q;
    logic [LANES-1:0]    be_q;

    logic [TAG_W-1:0]    in_tag;
    logic [LANE_W-1:0]   in_lane;
    logic                hit;

    assign in_tag  = I_ADDR[ADDR_W-1:LANE_W];
    assign in_lane = I_ADDR[LANE_W-1:0];
    assign hit     = valid_q && (tag_q == in_tag);

    // A hit stays in IDLE but drops ready for one cycle to mark completion.
    always_ff @(posedge I_CLK or negedge I_RSTn) begin
        if (!I_RSTn) begin
            state_q    <= IDLE;
            ready_q    <= 1'b1;
            req_tag_q  <= '0;
            req_lane_q <= '0;
            tag_q      <= '0;
            valid_q    <= 1'b0;
            line_q     <= '0;
            dout_q     <= '0;
            rd_q       <= 1'b0;
            we_q       <= 1'b0;
            ddr_din_q  <= '0;
            be_q       <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!ready_q) begin
                        ready_q <= 1'b1;
                    end else if (I_WR) begin
                        req_tag_q  <= in_tag;
                        req_lane_q <= in_lane;
                        ddr_din_q  <= {LANES{I_DIN}};
                        be_q       <= lane_be(in_lane);
                        we_q       <= 1'b1;
                        ready_q    <= 1'b0;
                        state_q    <= WR_REQ;
                        if (hit)
                            line_q[{in_lane, 3'b000} +: 8] <= I_DIN;
                    end else if (I_RD) begin
                        req_tag_q  <= in_tag;
                        req_lane_q <= in_lane;
                        ready_q    <= 1'b0;
                        if (hit) begin
                            dout_q <= line_q[{in_lane, 3'b000} +: 8];
                        end else begin
                            rd_q    <= 1'b1;
                            state_q <= RD_REQ;
                        end
                    end
                end
                RD_REQ: begin
                    if (!I_DDRAM_BUSY) begin
                        rd_q    <= 1'b0;
                        state_q <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (I_DDRAM_DOUT_READY) begin
                        line_q  <= I_DDRAM_DOUT;
                        tag_q   <= req_tag_q;
                        valid_q <= 1'b1;
                        dout_q  <= I_DDRAM_DOUT[{req_lane_q, 3'b000} +: 8];
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                WR_REQ: begin
                    if (!I_DDRAM_BUSY) begin
                        we_q      <= 1'b0;
                        be_q      <= '0;
                        ddr_din_q <= '0;
                        ready_q   <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign O_DOUT           = dout_q;
    assign O_READY          = ready_q;
    assign O_DDRAM_ADDR     = {BASE, req_tag_q};
    assign O_DDRAM_BURSTCNT = 8'd1;
    assign O_DDRAM_RD       = rd_q;
    assign O_DDRAM_WE       = we_q;
    assign O_DDRAM_DIN      = ddr_din_q;
    assign O_DDRAM_BE       = be_q;

endmodule

// File: tb/tb_wav_ddr_byte_port.sv
// Directed bench for wav_ddr_byte_port: read data is predicted into a
// queue at request time and popped when the port reports completion.
module tb_wav_ddr_byte_port;

    logic        clk;
    logic        rst_n;
    logic [27:0] addr;
    logic        rd;
    logic        wr;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic        ready;
    logic [28:0] d_addr;
    logic [7:0]  d_burst;
    logic        d_rd;
    logic        d_we;
    logic [63:0] d_din;
    logic [7:0]  d_be;
    logic        d_busy;
    logic [63:0] d_dout;
    logic        d_dout_rdy;

    int tests = 0;
    int fails = 0;
    int rd_cnt = 0;
    int we_cnt = 0;
    int bus_err = 0;
    int snap_rd;
    int snap_we;
    logic [7:0] exp_q[$];

    wav_ddr_byte_port #(.BASE(4'h3)) dut (
        .I_CLK              (clk),
        .I_RSTn             (rst_n),
        .I_ADDR             (addr),
        .I_RD               (rd),
        .I_WR               (wr),
        .I_DIN              (din),
        .O_DOUT             (dout),
        .O_READY            (ready),
        .O_DDRAM_ADDR       (d_addr),
        .O_DDRAM_BURSTCNT   (d_burst),
        .O_DDRAM_RD         (d_rd),
        .O_DDRAM_WE         (d_we),
        .O_DDRAM_DIN        (d_din),
        .O_DDRAM_BE         (d_be),
        .I_DDRAM_BUSY       (d_busy),
        .I_DDRAM_DOUT       (d_dout),
        .I_DDRAM_DOUT_READY (d_dout_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (d_rd) rd_cnt++;
        if (d_we) we_cnt++;
        if (d_rd && d_we) bus_err++;
        if (ready && (d_rd || d_we)) bus_err++;
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(ready), 64'd1);
    endtask

    task automatic pop_check(input string tag);
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s: got no prediction, want one queued", tag);
        end else begin
            check(tag, 64'(dout), 64'(exp_q.pop_front()));
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        addr       = '0;
        rd         = 1'b0;
        wr         = 1'b0;
        din        = '0;
        d_busy     = 1'b0;
        d_dout     = '0;
        d_dout_rdy = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_dout", 64'(dout), 64'd0);
        check("rst_cmd", {62'd0, d_rd, d_we}, 64'd0);
        check("rst_be_din", d_din | 64'(d_be), 64'd0);
        check("burstcnt", 64'(d_burst), 64'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // cold read, lane 5 of a freshly fetched word
        addr = 28'h0000005;
        rd   = 1'b1;
        exp_q.push_back(8'h66);
        @(negedge clk);
        rd   = 1'b0;
        addr = 28'h0FFFFFF;
        check("cold_rd_cmd", 64'(d_rd), 64'd1);
        check("cold_addr", 64'(d_addr), 64'({4'h3, 25'h0}));
        check("cold_busy", 64'(ready), 64'd0);
        repeat (2) @(negedge clk);
        d_dout     = 64'h8877665544332211;
        d_dout_rdy = 1'b1;
        @(negedge clk);
        d_dout_rdy = 1'b0;
        d_dout     = '0;
        wait_ready("cold_ready");
        pop_check("cold_dout");
        check("cold_rd_once", 64'(rd_cnt), 64'd1);

        // hit on the cached word
        snap_rd = rd_cnt;
        addr = 28'h0000002;
        rd   = 1'b1;
        exp_q.push_back(8'h33);
        @(negedge clk);
        rd = 1'b0;
        check("hit_low", 64'(ready), 64'd0);
        @(negedge clk);
        check("hit_back", 64'(ready), 64'd1);
        pop_check("hit_dout");
        check("hit_no_rd", 64'(rd_cnt), 64'(snap_rd));

        // write stalled by BUSY for four cycles
        snap_we = we_cnt;
        d_busy = 1'b1;
        addr   = 28'h000000B;
        din    = 8'hA5;
        wr     = 1'b1;
        @(negedge clk);
        wr   = 1'b0;
        addr = '0;
        din  = '0;
        check("wr_we", 64'(d_we), 64'd1);
        check("wr_be", 64'(d_be), 64'h08);
        check("wr_din", d_din, 64'hA5A5A5A5A5A5A5A5);
        check("wr_addr", 64'(d_addr), 64'({4'h3, 25'h1}));
        repeat (4) @(negedge clk);
        check("wr_held_be", 64'(d_be), 64'h08);
        d_busy = 1'b0;
        @(negedge clk);
        check("wr_done_we", 64'(d_we), 64'd0);
        check("wr_we_cycles", 64'(we_cnt - snap_we), 64'd5);
        wait_ready("wr_ready");

        // write-through into the cached word, then read it back
        addr = 28'h0000001;
        din  = 8'h7E;
        wr   = 1'b1;
        @(negedge clk);
        wr = 1'b0;
        wait_ready("wt_ready");
        snap_rd = rd_cnt;
        addr = 28'h0000001;
        rd   = 1'b1;
        exp_q.push_back(8'h7E);
        @(negedge clk);
        rd = 1'b0;
        check("wt_low", 64'(ready), 64'd0);
        @(negedge clk);
        check("wt_back", 64'(ready), 64'd1);
        pop_check("wt_dout");
        check("wt_no_rd", 64'(rd_cnt), 64'(snap_rd));

        // RD+WR together, then RD pulsed while the write is stalled
        snap_rd = rd_cnt;
        snap_we = we_cnt;
        d_busy = 1'b1;
        addr   = 28'h0000010;
        din    = 8'h3C;
        rd     = 1'b1;
        wr     = 1'b1;
        @(negedge clk);
        wr = 1'b0;
        rd = 1'b0;
        check("both_we", 64'(d_we), 64'd1);
        check("both_be", 64'(d_be), 64'h01);
        addr = 28'h0000018;
        rd   = 1'b1;
        @(negedge clk);
        rd     = 1'b0;
        d_busy = 1'b0;
        @(negedge clk);
        wait_ready("both_ready");
        repeat (3) @(negedge clk);
        check("both_no_rd", 64'(rd_cnt), 64'(snap_rd));
        check("both_we_cycles", 64'(we_cnt - snap_we), 64'd2);
        check("both_dout_hold", 64'(dout), 64'h7E);

        // reset while waiting for read data
        addr = 28'h0000020;
        rd   = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        check("mr_rd_cmd", 64'(d_rd), 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mr_ready", 64'(ready), 64'd1);
        check("mr_dout", 64'(dout), 64'd0);
        check("mr_cmd", {62'd0, d_rd, d_we}, 64'd0);
        check("mr_be_din", d_din | 64'(d_be), 64'd0);
        @(negedge clk);
        rst_n      = 1'b1;
        d_dout     = 64'h1111111111111111;
        d_dout_rdy = 1'b1;
        @(negedge clk);
        d_dout_rdy = 1'b0;
        check("mr_late_dout", 64'(dout), 64'd0);
        check("mr_late_ready", 64'(ready), 64'd1);
        snap_rd = rd_cnt;
        addr = 28'h0000020;
        rd   = 1'b1;
        exp_q.push_back(8'h80);
        @(negedge clk);
        rd = 1'b0;
        check("mr_miss", 64'(d_rd), 64'd1);
        @(negedge clk);
        d_dout     = 64'hF0E0D0C0B0A09080;
        d_dout_rdy = 1'b1;
        @(negedge clk);
        d_dout_rdy = 1'b0;
        wait_ready("mr_ready2");
        pop_check("mr_dout2");
        check("mr_rd_once", 64'(rd_cnt - snap_rd), 64'd1);

        check("bus_rules", 64'(bus_err), 64'd0);
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
